// File: rtl/regs_wb_arb_pkg.sv
// Shared constants for the GPR write-back arbiter: register-file geometry and write-source encoding.
// RV32E_BASE_ISA shrinks the register file to 16 entries.
package regs_wb_arb_pkg;

`ifdef RV32E_BASE_ISA
   localparam int WB_NREG = 16;
`else
   localparam int WB_NREG = 32;
`endif
   localparam int WB_AW = 5;
   localparam int WB_DW = 32;

   typedef enum logic [1:0] {
      WB_SRC_EX  = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_DIV = 2'd2,
      WB_SRC_BUS = 2'd3
   } wb_src_e;

endpackage

// File: rtl/regs_wb_arb_sb.sv
// Busy-bit scoreboard for long-latency destinations; lookup is combinational, set/clear land next cycle.
// Never stalls; x0 and addresses at or above NREG are never marked busy.
module regs_wb_arb_sb
   import regs_wb_arb_pkg::*;
#(
   parameter int NREG = WB_NREG,
   parameter int AW   = WB_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] raddr1_i,
   input  logic [AW-1:0] raddr2_i,
   output logic          busy1_o,
   output logic          busy2_o
);

   logic [NREG-1:0] busy;

   // One-hot decode that leaves x0 and out-of-range addresses all-zero.
   function automatic logic [NREG-1:0] dec(input logic [AW-1:0] a);
      logic [NREG-1:0] m;
      m = '0;
      for (int i = 1; i < NREG; i++) m[i] = (int'(a) == i);
      return m;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~({NREG{clr_i}} & dec(clr_addr_i))) | ({NREG{set_i}} & dec(set_addr_i));
      end
   end

   assign busy1_o = |(busy & dec(raddr1_i));
   assign busy2_o = |(busy & dec(raddr2_i));

endmodule

// File: rtl/regs_wb_arb.sv
// Four-source write-back arbiter (EX > round-robin MEM/DIV > BUS) into one registered GPR write port; 1-cycle latency.
// EX is never stalled and blocks all others; WB_FWD_EN swaps the write-port hazard term for forwarding outputs.
module regs_wb_arb
   import regs_wb_arb_pkg::*;
#(
   parameter int NREG = WB_NREG,
   parameter int AW   = WB_AW,
   parameter int DW   = WB_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_vld_i,
   input  logic [AW-1:0] ex_addr_i,
   input  logic [DW-1:0] ex_data_i,
   input  logic          mem_vld_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic [DW-1:0] mem_data_i,
   output logic          mem_rdy_o,
   input  logic          div_vld_i,
   input  logic [AW-1:0] div_addr_i,
   input  logic [DW-1:0] div_data_i,
   output logic          div_rdy_o,
   input  logic          bus_vld_i,
   input  logic [AW-1:0] bus_addr_i,
   input  logic [DW-1:0] bus_data_i,
   output logic          bus_rdy_o,
   input  logic          sb_set_i,
   input  logic [AW-1:0] sb_addr_i,
   input  logic [AW-1:0] raddr1_i,
   input  logic [AW-1:0] raddr2_i,
   output logic          hazard_o,
`ifdef WB_FWD_EN
   output logic          fwd1_vld_o,
   output logic [DW-1:0] fwd1_data_o,
   output logic          fwd2_vld_o,
   output logic [DW-1:0] fwd2_data_o,
`endif
   output logic          we_o,
   output logic [AW-1:0] waddr_o,
   output logic [DW-1:0] wdata_o
);

   logic          rr_div;   // set: DIV wins the next MEM/DIV contest
   logic          mem_go, div_go, bus_go, any_go, sel_ok;
   logic          busy1, busy2;
   wb_src_e       src;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   // Each rdy depends only on the other sources, never on its own vld.
   assign mem_rdy_o = rst_n & ~ex_vld_i & (~div_vld_i | ~rr_div);
   assign div_rdy_o = rst_n & ~ex_vld_i & (~mem_vld_i | rr_div);
   assign bus_rdy_o = rst_n & ~ex_vld_i & ~mem_vld_i & ~div_vld_i;

   assign mem_go = mem_vld_i & mem_rdy_o;
   assign div_go = div_vld_i & div_rdy_o;
   assign bus_go = bus_vld_i & bus_rdy_o;
   assign any_go = ex_vld_i | mem_go | div_go | bus_go;

   always_comb begin
      src = WB_SRC_BUS;
      if (ex_vld_i)    src = WB_SRC_EX;
      else if (mem_go) src = WB_SRC_MEM;
      else if (div_go) src = WB_SRC_DIV;
      case (src)
         WB_SRC_EX:  begin sel_addr = ex_addr_i;  sel_data = ex_data_i;  end
         WB_SRC_MEM: begin sel_addr = mem_addr_i; sel_data = mem_data_i; end
         WB_SRC_DIV: begin sel_addr = div_addr_i; sel_data = div_data_i; end
         default:    begin sel_addr = bus_addr_i; sel_data = bus_data_i; end
      endcase
   end

   // x0 and nonexistent registers complete the handshake but never reach the GPR file.
   assign sel_ok = (sel_addr != '0) && (int'(sel_addr) < NREG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
         rr_div  <= 1'b0;
      end else begin
         we_o <= any_go & sel_ok;
         if (any_go) begin
            waddr_o <= sel_addr;
            wdata_o <= sel_data;
         end
         if (mem_go)      rr_div <= 1'b1;
         else if (div_go) rr_div <= 1'b0;
      end
   end

   regs_wb_arb_sb #(.NREG(NREG), .AW(AW)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (sb_set_i),
      .set_addr_i (sb_addr_i),
      .clr_i      (mem_go | div_go),
      .clr_addr_i (mem_go ? mem_addr_i : div_addr_i),
      .raddr1_i   (raddr1_i),
      .raddr2_i   (raddr2_i),
      .busy1_o    (busy1),
      .busy2_o    (busy2)
   );

`ifdef WB_FWD_EN
   assign fwd1_vld_o  = we_o & (waddr_o == raddr1_i) & (raddr1_i != '0);
   assign fwd2_vld_o  = we_o & (waddr_o == raddr2_i) & (raddr2_i != '0);
   assign fwd1_data_o = wdata_o;
   assign fwd2_data_o = wdata_o;
   assign hazard_o    = busy1 | busy2;
`else
   assign hazard_o = busy1 | busy2 |
                     (we_o & (((waddr_o == raddr1_i) & (raddr1_i != '0)) |
                              ((waddr_o == raddr2_i) & (raddr2_i != '0))));
`endif

endmodule

// File: tb/tb_regs_wb_arb.sv
// Scoreboard bench for regs_wb_arb: expected writes queued on each drive cycle, popped after the register edge.
module tb_regs_wb_arb;
   import regs_wb_arb_pkg::*;

   logic        clk, rst_n;
   logic        ex_vld, mem_vld, div_vld, bus_vld, sb_set;
   logic [4:0]  ex_addr, mem_addr, div_addr, bus_addr, sb_addr, raddr1, raddr2;
   logic [31:0] ex_data, mem_data, div_data, bus_data;
   logic        mem_rdy, div_rdy, bus_rdy, hazard, we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
`ifdef WB_FWD_EN
   logic        fwd1_vld, fwd2_vld;
   logic [31:0] fwd1_data, fwd2_data;
`endif

   regs_wb_arb dut (
      .clk(clk), .rst_n(rst_n),
      .ex_vld_i(ex_vld), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
      .mem_vld_i(mem_vld), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_rdy_o(mem_rdy),
      .div_vld_i(div_vld), .div_addr_i(div_addr), .div_data_i(div_data), .div_rdy_o(div_rdy),
      .bus_vld_i(bus_vld), .bus_addr_i(bus_addr), .bus_data_i(bus_data), .bus_rdy_o(bus_rdy),
      .sb_set_i(sb_set), .sb_addr_i(sb_addr),
      .raddr1_i(raddr1), .raddr2_i(raddr2), .hazard_o(hazard),
`ifdef WB_FWD_EN
      .fwd1_vld_o(fwd1_vld), .fwd1_data_o(fwd1_data),
      .fwd2_vld_o(fwd2_vld), .fwd2_data_o(fwd2_data),
`endif
      .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t        q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic        m_ptr_div;
   logic [31:0] m_busy;
   logic        m_we;
   logic [4:0]  m_a;
   logic [31:0] m_d;
   logic        g_ex, g_mem, g_div, g_bus;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      else n_pass++;
   endtask

   function automatic logic rd_busy(input logic [4:0] r);
      return (r != 5'd0) && m_busy[r];
   endfunction

   function automatic logic wr_hit(input logic [4:0] r);
      return m_we && (m_a == r) && (r != 5'd0);
   endfunction

   // Called at posedge+1: checks at posedge+5, models the edge, returns at next posedge+1.
   task automatic step();
      exp_t        e, n;
      logic        em, ed, eb, hz, go;
      logic [4:0]  ga;
      logic [31:0] gd;
      #4;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("we", we, e.we);
         check("waddr", waddr, e.a);
         check("wdata", wdata, e.d);
      end
      em = !ex_vld && (!div_vld || !m_ptr_div);
      ed = !ex_vld && (!mem_vld || m_ptr_div);
      eb = !ex_vld && !mem_vld && !div_vld;
      check("mem_rdy", mem_rdy, em);
      check("div_rdy", div_rdy, ed);
      check("bus_rdy", bus_rdy, eb);
      hz = rd_busy(raddr1) || rd_busy(raddr2);
`ifdef WB_FWD_EN
      check("fwd1_vld", fwd1_vld, wr_hit(raddr1));
      check("fwd2_vld", fwd2_vld, wr_hit(raddr2));
      if (wr_hit(raddr1)) check("fwd1_data", fwd1_data, m_d);
      if (wr_hit(raddr2)) check("fwd2_data", fwd2_data, m_d);
`else
      hz = hz || wr_hit(raddr1) || wr_hit(raddr2);
`endif
      check("hazard", hazard, hz);
      g_ex  = ex_vld;
      g_mem = mem_vld && em;
      g_div = div_vld && ed;
      g_bus = bus_vld && eb;
      go = g_ex || g_mem || g_div || g_bus;
      if (g_ex)       begin ga = ex_addr;  gd = ex_data;  end
      else if (g_mem) begin ga = mem_addr; gd = mem_data; end
      else if (g_div) begin ga = div_addr; gd = div_data; end
      else            begin ga = bus_addr; gd = bus_data; end
      n.we = go && (ga != 5'd0) && (int'(ga) < WB_NREG);
      n.a  = go ? ga : m_a;
      n.d  = go ? gd : m_d;
      q.push_back(n);
      m_we = n.we; m_a = n.a; m_d = n.d;
      if (g_mem) m_ptr_div = 1'b1;
      else if (g_div) m_ptr_div = 1'b0;
      if (g_mem) m_busy[mem_addr] = 1'b0;
      if (g_div) m_busy[div_addr] = 1'b0;
      if (sb_set && sb_addr != 5'd0 && int'(sb_addr) < WB_NREG) m_busy[sb_addr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4;
      check("rst_mem_rdy", mem_rdy, 1'b0);
      check("rst_div_rdy", div_rdy, 1'b0);
      check("rst_bus_rdy", bus_rdy, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_waddr", waddr, 5'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_hazard", hazard, 1'b0);
      q.delete();
      m_ptr_div = 1'b0; m_busy = '0; m_we = 1'b0; m_a = '0; m_d = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      {ex_vld, mem_vld, div_vld, bus_vld, sb_set} = '0;
      {ex_addr, mem_addr, div_addr, bus_addr, sb_addr, raddr1, raddr2} = '0;
      {ex_data, mem_data, div_data, bus_data} = '0;
      @(posedge clk);
      #1;
      mem_vld = 1'b1; div_vld = 1'b1; bus_vld = 1'b1;
      do_reset();

      // EX overrides every other requester
      ex_vld = 1'b1; ex_addr = 5'd5; ex_data = 32'h1234;
      mem_addr = 5'd10; mem_data = 32'hA0; div_addr = 5'd14; div_data = 32'hD0;
      step();
      ex_vld = 1'b0; bus_vld = 1'b0;

      // MEM/DIV alternate, MEM first after reset
      for (int i = 0; i < 4; i++) begin
         step();
         if (g_mem) begin mem_addr = mem_addr + 5'd1; mem_data = mem_data + 32'd1; end
         if (g_div) begin div_addr = div_addr + 5'd1; div_data = div_data + 32'd1; end
      end
      mem_vld = 1'b0; div_vld = 1'b0;

      // scoreboard set, then cleared by a load write
      sb_set = 1'b1; sb_addr = 5'd7;
      step();
      sb_set = 1'b0; raddr1 = 5'd7;
      step();
      mem_vld = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
      step();
      mem_vld = 1'b0;
      step();
      step();

      // set beats a same-cycle clear
      sb_set = 1'b1; sb_addr = 5'd9; raddr2 = 5'd9;
      step();
      div_vld = 1'b1; div_addr = 5'd9; div_data = 32'h99;
      step();
      sb_set = 1'b0; div_vld = 1'b0;
      step();
      div_vld = 1'b1; div_data = 32'h9A;
      step();
      div_vld = 1'b0;
      step();
      step();
      raddr1 = 5'd0; raddr2 = 5'd0;

      // bus write to x0, then bus waiting behind a load
      bus_vld = 1'b1; bus_addr = 5'd0; bus_data = 32'hFFFF_FFFF;
      step();
      bus_addr = 5'd4; bus_data = 32'h44; mem_vld = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
      step();
      mem_vld = 1'b0;
      step();
      bus_vld = 1'b0;
      step();

      // register 20 (nonexistent under RV32E)
      ex_vld = 1'b1; ex_addr = 5'd20; ex_data = 32'h55;
      step();
      ex_vld = 1'b0; sb_set = 1'b1; sb_addr = 5'd20;
      step();
      sb_set = 1'b0; raddr1 = 5'd20;
      step();
      raddr1 = 5'd0;

      // read of a register being written this cycle
      ex_vld = 1'b1; ex_addr = 5'd3; ex_data = 32'hAA;
      step();
      ex_vld = 1'b0; raddr1 = 5'd3; raddr2 = 5'd2;
      step();
      raddr1 = 5'd0; raddr2 = 5'd0;
      step();

      // reset mid-operation drops busy state and restarts the pointer at MEM
      sb_set = 1'b1; sb_addr = 5'd12;
      mem_vld = 1'b1; mem_addr = 5'd1; mem_data = 32'h11;
      step();
      sb_set = 1'b0; raddr1 = 5'd12; div_vld = 1'b1; div_addr = 5'd2; div_data = 32'h22;
      step();
      do_reset();
      step();
      mem_vld = 1'b0;
      step();
      div_vld = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
